// File: rtl/ha_rr_arbiter.sv
// rtl/ha_rr_arbiter.sv - round-robin arbiter sharing one bitwise half-adder among requesters
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, same packing
//   req_ready  one-hot (or zero) accept to the granted requester
//   rsp_valid  response slot holds a result
//   rsp_ready  consumer accepts the response
//   rsp_id     index of the requester that produced the result
//   rsp_sum    a ^ b of the accepted request
//   rsp_carry  a & b of the accepted request
//   busy_cnt   accepted request count, saturating at 255
module ha_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 2,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic [W-1:0]         rsp_carry,
    output logic [7:0]           busy_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] next_ptr;
    logic           found;
    logic           slot_free;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    int             idx;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    assign next_ptr = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    assign sel_a    = req_a[gnt*W +: W];
    assign sel_b    = req_b[gnt*W +: W];

    // A draining slot can be refilled in the same cycle, so back-to-back
    // results need no bubble. rst_n gates ready so nothing is offered in reset.
    always_comb begin
        state_d   = state_q;
        slot_free = (state_q == EMPTY) || rsp_ready;
        req_ready = '0;
        if (found && slot_free && rst_n) begin
            req_ready[gnt] = 1'b1;
        end
        accept = |(req_valid & req_ready);
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign rsp_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= '0;
            busy_cnt  <= '0;
        end else if (accept) begin
            rr_ptr    <= next_ptr;
            rsp_id    <= gnt;
            rsp_sum   <= sel_a ^ sel_b;
            rsp_carry <= sel_a & sel_b;
            if (busy_cnt != 8'hFF) begin
                busy_cnt <= busy_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ha_rr_arbiter.sv
// tb/tb_ha_rr_arbiter.sv - scoreboard testbench for ha_rr_arbiter
module tb_ha_rr_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic [W-1:0]   rsp_carry;
    logic [7:0]     busy_cnt;

    ha_rr_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] q[$];
    int         m_ptr  = 0;
    int         m_cnt  = 0;
    bit         m_full = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            set_req(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ptr  = 0;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        bit         slot;
        bit         fnd;
        int         g;
        int         ix;
        logic [3:0] exp_rdy;
        logic [1:0] a;
        logic [1:0] b;
        #1;
        slot = !m_full || rsp_ready;
        fnd  = 1'b0;
        g    = 0;
        for (int k = 0; k < N; k++) begin
            ix = (m_ptr + k) % N;
            if (!fnd && req_valid[ix]) begin
                fnd = 1'b1;
                g   = ix;
            end
        end
        exp_rdy = (fnd && slot) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_full);
        check("busy_cnt", busy_cnt, m_cnt);
        if (m_full && q.size() > 0) begin
            check("rsp_data", {rsp_id, rsp_sum, rsp_carry}, q[0]);
            if (rsp_ready) begin
                void'(q.pop_front());
            end
        end
        if (fnd && slot) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            q.push_back({2'(g), a ^ b, a & b});
            m_ptr = (g + 1) % N;
            if (m_cnt < 255) begin
                m_cnt++;
            end
        end
        m_full = (fnd && slot) || (m_full && !rsp_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy_cnt", busy_cnt, 0);
        check("rst_rsp_data", {rsp_id, rsp_sum, rsp_carry}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 2'b00, 2'b11);
        tick();
        check("t2_sum", rsp_sum, 2'b11);
        check("t2_carry", rsp_carry, 2'b00);
        check("t2_id", rsp_id, 0);
        req_valid = '0;
        tick();

        // Fairness: all valid continuously
        req_valid = 4'b1111;
        rand_ops();
        set_req(1, 2'b01, 2'b11);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_id == 2'd1) begin
                check("t3_sum", rsp_sum, 2'b10);
                check("t3_carry", rsp_carry, 2'b01);
            end
        end

        // Backpressure then release with same-cycle refill
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        tick();

        // Wrap/skip: pointer to 3, only requester 1 valid
        req_valid = '0;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b0010;
        set_req(1, 2'b01, 2'b10);
        tick();
        check("t5_id", rsp_id, 1);
        check("t5_sum", rsp_sum, 2'b11);
        check("t5_carry", rsp_carry, 2'b00);
        req_valid = 4'b1111;
        #1;
        check("t5_ptr", req_ready, 4'b0100);
        tick();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = 4'($urandom_range(1, 15));
            tick();
        end
        check("sat_cnt", busy_cnt, 255);
        tick();
        check("sat_hold", busy_cnt, 255);

        // Asynchronous reset while the slot is full and stalled
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy_cnt", busy_cnt, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_rsp_data", {rsp_id, rsp_sum, rsp_carry}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        rsp_ready = 1'b1;
        #1;
        check("arst_ptr", req_ready, 4'b0001);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
